// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the serial subtractor's FSM states.
package alu_pkg;

    // Default datapath width, common to the adder and subtractor blocks.
    localparam int ALU_WIDTH = 32;

    // Serial subtractor sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - b_in, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor_32_bit.sv
// Digit-serial subtractor: diff = a - b - b_in, DIGIT_W bits per clock,
// borrow carried between digits in a register. start/busy/done handshake.
module serial_subtractor_32_bit
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int DIGIT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N_DIG = WIDTH / DIGIT_W;
    localparam int CNT_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(N_DIG - 1);

    sub_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b_out_q, b_out_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Per-cycle digit datapath: borrow chain through DIGIT_W cells.
    logic [DIGIT_W:0]   chain;
    logic [DIGIT_W-1:0] dig;

    assign chain[0] = borrow_q;

    generate
        for (genvar i = 0; i < DIGIT_W; i++) begin : g_cell
            full_subtractor u_fs (
                .a     (a_q[i]),
                .b     (b_q[i]),
                .b_in  (chain[i]),
                .d     (dig[i]),
                .b_out (chain[i+1])
            );
        end
    endgenerate

    // Result shift register fills from the MSB side, so after the last digit
    // it holds the complete difference in natural bit order.
    logic [WIDTH+DIGIT_W-1:0] acc_wide;
    logic [WIDTH-1:0]         acc_next;
    logic                     accept;

    assign acc_wide = {dig, acc_q};
    assign acc_next = acc_wide[WIDTH+DIGIT_W-1:DIGIT_W];

    // A new operation is taken when idle, or at the edge closing the done
    // cycle, which gives back-to-back issue every N_DIG+1 cycles.
    assign accept = start && (state_q == IDLE || state_q == DONE);

    // Next-state and datapath update logic.
    always_comb begin
        // NOTE: every _d starts from its _q, so no path leaves a signal
        // unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        acc_d    = acc_q;
        diff_d   = diff_q;
        b_out_d  = b_out_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: ;
            RUN: begin
                a_d      = a_q >> DIGIT_W;
                b_d      = b_q >> DIGIT_W;
                borrow_d = chain[DIGIT_W];
                acc_d    = acc_next;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_DIG) begin
                    // The top digit of the operand registers still holds the
                    // latched operand MSBs, so overflow uses latched signs.
                    diff_d  = acc_next;
                    b_out_d = chain[DIGIT_W];
                    ovf_d   = (a_q[DIGIT_W-1] != b_q[DIGIT_W-1]) &&
                              (acc_next[WIDTH-1] != a_q[DIGIT_W-1]);
                    zero_d  = (acc_next == '0);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            a_d      = a;
            b_d      = b;
            borrow_d = b_in;
            cnt_d    = '0;
            state_d  = RUN;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: datapath registers are reset along with control so every
        // output and internal value is defined right after rst; there is no
        // memory array here, so this costs only reset fan-out.
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            acc_q    <= '0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            acc_q    <= acc_d;
            diff_q   <= diff_d;
            b_out_q  <= b_out_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign diff     = diff_q;
    assign b_out    = b_out_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule
